// File: rtl/pattern_tx.sv
// pattern_tx
// Serial pattern transmitter, the counterpart of the serial pattern detector.
// A WIDTH-bit pattern is accepted on a start/ready handshake and shifted out
// LSB-first, one bit per clk. It can send repeat_cnt+1 copies, with
// GAP_CYCLES idle cycles between consecutive copies.
//
// Ports:
//   clk           clock, rising edge
//   reset_n       asynchronous active-low reset
//   start         transfer request, taken when start && ready
//   patternIn     pattern, latched on acceptance
//   repeat_cnt    extra copies, latched on acceptance
//   abort         synchronous cancel of the running transfer
//   ready         idle, a new transfer can be accepted
//   busy          shifting or in an inter-copy gap
//   serial_out    serial data (IDLE_LEVEL when serial_valid=0)
//   serial_valid  serial_out carries a pattern bit
//   done          one-cycle pulse after the last bit of the last copy
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | waiting for start, line at IDLE_LEVEL
// ST_SHIFT | driving pat[bit_idx] on the line
// ST_GAP   | idle gap between copies, gap_cnt counts down to 0

module pattern_tx #(
    parameter int   WIDTH      = 5,
    parameter int   REPEAT_W   = 4,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    patternIn,
    input  logic [REPEAT_W-1:0] repeat_cnt,
    input  logic                abort,
    output logic                ready,
    output logic                busy,
    output logic                serial_out,
    output logic                serial_valid,
    output logic                done
);

    localparam int IDX_W = $clog2(WIDTH);
    // A zero-cycle gap still needs a 1-bit counter to keep the vector legal.
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]          state,     state_n;
    logic [WIDTH-1:0]    pat,       pat_n;
    logic [REPEAT_W-1:0] reps_left, reps_n;
    logic [IDX_W-1:0]    bit_idx,   idx_n;
    logic [GAP_W-1:0]    gap_cnt,   gap_n;
    logic                done_n;

    always_comb begin
        state_n = state;
        pat_n   = pat;
        reps_n  = reps_left;
        idx_n   = bit_idx;
        gap_n   = gap_cnt;
        done_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                // abort is meaningless here, so start always wins
                if (start && ready) begin
                    pat_n   = patternIn;
                    reps_n  = repeat_cnt;
                    idx_n   = '0;
                    state_n = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_n = ST_IDLE;
                end else if (bit_idx == LAST_IDX) begin
                    if (reps_left == '0) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        reps_n = reps_left - 1'b1;
                        idx_n  = '0;
                        if (GAP_CYCLES > 0) begin
                            state_n = ST_GAP;
                            gap_n   = GAP_LOAD;
                        end
                    end
                end else begin
                    idx_n = bit_idx + IDX_W'(1);
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_n = ST_IDLE;
                end else if (gap_cnt == '0) begin
                    state_n = ST_SHIFT;
                    idx_n   = '0;
                end else begin
                    gap_n = gap_cnt - 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so the first bit
    // lands on the line the cycle after acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            pat          <= '0;
            reps_left    <= '0;
            bit_idx      <= '0;
            gap_cnt      <= '0;
            ready        <= 1'b1;
            busy         <= 1'b0;
            serial_out   <= IDLE_LEVEL;
            serial_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            pat          <= pat_n;
            reps_left    <= reps_n;
            bit_idx      <= idx_n;
            gap_cnt      <= gap_n;
            ready        <= (state_n == ST_IDLE);
            busy         <= (state_n != ST_IDLE);
            serial_out   <= (state_n == ST_SHIFT) ? pat_n[idx_n] : IDLE_LEVEL;
            serial_valid <= (state_n == ST_SHIFT);
            done         <= done_n;
        end
    end

endmodule

// File: tb/tb_pattern_tx.sv
// Bench for pattern_tx: one instance with a 3-cycle gap, one back-to-back,
// driven from shared inputs. Expected serial bits are queued when a transfer
// is started and popped as each DUT presents valid bits.
module tb_pattern_tx;
    localparam int W  = 5;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [W-1:0]  pattern_in = '0;
    logic [RW-1:0] repeat_cnt = '0;

    logic ready3, busy3, so3, sv3, done3;
    logic ready0, busy0, so0, sv0, done0;

    int n_checks = 0;
    int n_fail   = 0;
    bit q3[$];
    bit q0[$];

    always #5 clk = ~clk;

    pattern_tx #(.WIDTH(W), .REPEAT_W(RW), .GAP_CYCLES(3), .IDLE_LEVEL(1'b0)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start), .patternIn(pattern_in),
        .repeat_cnt(repeat_cnt), .abort(abort), .ready(ready3), .busy(busy3),
        .serial_out(so3), .serial_valid(sv3), .done(done3)
    );

    pattern_tx #(.WIDTH(W), .REPEAT_W(RW), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start), .patternIn(pattern_in),
        .repeat_cnt(repeat_cnt), .abort(abort), .ready(ready0), .busy(busy0),
        .serial_out(so0), .serial_valid(sv0), .done(done0)
    );

    // Scoreboard monitors
    always @(negedge clk) begin
        n_checks++;
        if (sv3) begin
            if (q3.size() == 0) begin
                n_fail++;
                $display("FAIL sb_gap3: got bit %0b, want no valid bit", so3);
            end else begin
                bit e;
                e = q3.pop_front();
                if (so3 !== e) begin
                    n_fail++;
                    $display("FAIL sb_gap3: got %0b want %0b", so3, e);
                end
            end
        end else if (so3 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_gap3: got %0b want 0", so3);
        end
    end

    always @(negedge clk) begin
        n_checks++;
        if (sv0) begin
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL sb_gap0: got bit %0b, want no valid bit", so0);
            end else begin
                bit e;
                e = q0.pop_front();
                if (so0 !== e) begin
                    n_fail++;
                    $display("FAIL sb_gap0: got %0b want %0b", so0, e);
                end
            end
        end else if (so0 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_gap0: got %0b want 0", so0);
        end
    end

    // Loopback detector fed by the gapped DUT, loaded with 5'b10110
    logic [W-1:0] det_sh;
    logic         det_patt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            det_sh   <= '0;
            det_patt <= 1'b0;
        end else begin
            det_patt <= sv3 && ({so3, det_sh[W-1:1]} == 5'b10110);
            if (sv3) det_sh <= {so3, det_sh[W-1:1]};
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Request a transfer and queue its first nbits bits (all if nbits<0).
    task automatic go(input logic [W-1:0] p, input logic [RW-1:0] r, input int nbits);
        int k;
        k = 0;
        start = 1'b1;
        pattern_in = p;
        repeat_cnt = r;
        for (int c = 0; c <= int'(r); c++)
            for (int b = 0; b < W; b++) begin
                if (nbits < 0 || k < nbits) begin
                    q3.push_back(p[b]);
                    q0.push_back(p[b]);
                end
                k++;
            end
        tick();
        start = 1'b0;
    endtask

    // Observe ncyc cycles numbered from c0 and record done / detector / valid timing.
    task automatic run(input int c0, input int ncyc, output int fd3, output int fd0,
                       output int nd3, output int nd0, output int fp, output logic [255:0] vm3);
        fd3 = 0; fd0 = 0; nd3 = 0; nd0 = 0; fp = 0; vm3 = '0;
        for (int c = c0; c < c0 + ncyc; c++) begin
            if (done3) begin nd3++; if (fd3 == 0) fd3 = c; end
            if (done0) begin nd0++; if (fd0 == 0) fd0 = c; end
            if (det_patt && fp == 0) fp = c;
            if (sv3) vm3[c] = 1'b1;
            tick();
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({ready3, busy3, sv3, done3, so3} !== 5'b10000) begin
            n_fail++; $display("FAIL reset3: got %b want 10000", {ready3, busy3, sv3, done3, so3});
        end
        n_checks++;
        if ({ready0, busy0, sv0, done0, so0} !== 5'b10000) begin
            n_fail++; $display("FAIL reset0: got %b want 10000", {ready0, busy0, sv0, done0, so0});
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        n_checks++;
        if ({ready3, busy3, sv3, done3} !== 4'b1000) begin
            n_fail++; $display("FAIL post_reset3: got %b want 1000", {ready3, busy3, sv3, done3});
        end
    endtask

    task automatic test_single;
        int fd3, fd0, nd3, nd0, fp;
        logic [255:0] vm, exp_vm;
        go(5'b10110, 4'd0, -1);
        n_checks++;
        if ({sv3, so3, busy3, ready3} !== 4'b1010) begin
            n_fail++; $display("FAIL single_first3: got %b want 1010", {sv3, so3, busy3, ready3});
        end
        n_checks++;
        if ({sv0, so0, busy0, ready0} !== 4'b1010) begin
            n_fail++; $display("FAIL single_first0: got %b want 1010", {sv0, so0, busy0, ready0});
        end
        run(1, 12, fd3, fd0, nd3, nd0, fp, vm);
        exp_vm = '0;
        for (int c = 1; c <= 5; c++) exp_vm[c] = 1'b1;
        n_checks++;
        if (fd3 !== 6 || nd3 !== 1) begin
            n_fail++; $display("FAIL single_done3: got cycle %0d count %0d want 6 1", fd3, nd3);
        end
        n_checks++;
        if (fd0 !== 6 || nd0 !== 1) begin
            n_fail++; $display("FAIL single_done0: got cycle %0d count %0d want 6 1", fd0, nd0);
        end
        n_checks++;
        if (vm !== exp_vm) begin
            n_fail++; $display("FAIL single_valid: got %0h want %0h", vm[63:0], exp_vm[63:0]);
        end
        n_checks++;
        if (fp !== 6) begin
            n_fail++; $display("FAIL loopback_patt: got cycle %0d want 6", fp);
        end
    endtask

    task automatic test_repeat_gap;
        int fd3, fd0, nd3, nd0, fp;
        logic [255:0] vm, exp_vm;
        go(5'b11001, 4'd2, -1);
        run(1, 30, fd3, fd0, nd3, nd0, fp, vm);
        exp_vm = '0;
        for (int k = 0; k < 3; k++)
            for (int b = 0; b < 5; b++) exp_vm[1 + k * 8 + b] = 1'b1;
        n_checks++;
        if (fd3 !== 22 || nd3 !== 1) begin
            n_fail++; $display("FAIL gap_done3: got cycle %0d count %0d want 22 1", fd3, nd3);
        end
        n_checks++;
        if (fd0 !== 16 || nd0 !== 1) begin
            n_fail++; $display("FAIL nogap_done0: got cycle %0d count %0d want 16 1", fd0, nd0);
        end
        n_checks++;
        if (vm !== exp_vm) begin
            n_fail++; $display("FAIL gap_valid: got %0h want %0h", vm[63:0], exp_vm[63:0]);
        end
    endtask

    task automatic test_start_ignored;
        int fd3, fd0, nd3, nd0, fp;
        logic [255:0] vm, exp_vm;
        go(5'b10011, 4'd1, -1);
        tick();
        tick();
        start = 1'b1;
        pattern_in = 5'b01010;
        repeat_cnt = 4'd5;
        tick();
        start = 1'b0;
        run(4, 20, fd3, fd0, nd3, nd0, fp, vm);
        exp_vm = '0;
        exp_vm[4] = 1'b1;
        exp_vm[5] = 1'b1;
        for (int c = 9; c <= 13; c++) exp_vm[c] = 1'b1;
        n_checks++;
        if (fd3 !== 14 || nd3 !== 1) begin
            n_fail++; $display("FAIL busy_start_done3: got cycle %0d count %0d want 14 1", fd3, nd3);
        end
        n_checks++;
        if (fd0 !== 11 || nd0 !== 1) begin
            n_fail++; $display("FAIL busy_start_done0: got cycle %0d count %0d want 11 1", fd0, nd0);
        end
        n_checks++;
        if (vm !== exp_vm) begin
            n_fail++; $display("FAIL busy_start_valid: got %0h want %0h", vm[63:0], exp_vm[63:0]);
        end
    endtask

    task automatic test_abort;
        int fd3, fd0, nd3, nd0, fp;
        logic [255:0] vm;
        go(5'b11010, 4'd2, 3);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if ({sv3, so3, ready3, busy3, done3} !== 5'b00100) begin
            n_fail++; $display("FAIL abort3: got %b want 00100", {sv3, so3, ready3, busy3, done3});
        end
        n_checks++;
        if ({sv0, so0, ready0, busy0, done0} !== 5'b00100) begin
            n_fail++; $display("FAIL abort0: got %b want 00100", {sv0, so0, ready0, busy0, done0});
        end
        run(4, 10, fd3, fd0, nd3, nd0, fp, vm);
        n_checks++;
        if (nd3 !== 0 || nd0 !== 0 || vm !== '0) begin
            n_fail++; $display("FAIL abort_quiet: got done %0d %0d valid %0h want 0 0 0", nd3, nd0, vm[63:0]);
        end
        n_checks++;
        if (q3.size() !== 0 || q0.size() !== 0) begin
            n_fail++; $display("FAIL abort_queue: got %0d %0d pending want 0 0", q3.size(), q0.size());
        end
        // abort together with start in IDLE: start wins
        abort = 1'b1;
        go(5'b00111, 4'd0, -1);
        abort = 1'b0;
        n_checks++;
        if ({sv3, so3, sv0, so0} !== 4'b1111) begin
            n_fail++; $display("FAIL abort_start: got %b want 1111", {sv3, so3, sv0, so0});
        end
        run(1, 10, fd3, fd0, nd3, nd0, fp, vm);
        n_checks++;
        if (fd3 !== 6 || fd0 !== 6) begin
            n_fail++; $display("FAIL abort_restart_done: got %0d %0d want 6 6", fd3, fd0);
        end
    endtask

    task automatic test_back_to_back;
        int fd3, fd0, nd3, nd0, fp;
        logic [255:0] vm;
        go(5'b10101, 4'd1, -1);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({ready3, busy3, sv3, done3, so3} !== 5'b10000) begin
            n_fail++; $display("FAIL midreset3: got %b want 10000", {ready3, busy3, sv3, done3, so3});
        end
        n_checks++;
        if ({ready0, busy0, sv0, done0, so0} !== 5'b10000) begin
            n_fail++; $display("FAIL midreset0: got %b want 10000", {ready0, busy0, sv0, done0, so0});
        end
        q3.delete();
        q0.delete();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        go(5'b01011, 4'd0, -1);
        repeat (5) tick();
        n_checks++;
        if ({done3, ready3, sv3, done0, ready0, sv0} !== 6'b110110) begin
            n_fail++; $display("FAIL b2b_done: got %b want 110110", {done3, ready3, sv3, done0, ready0, sv0});
        end
        go(5'b10011, 4'd0, -1);
        n_checks++;
        if ({sv3, so3, sv0, so0} !== 4'b1111) begin
            n_fail++; $display("FAIL b2b_first: got %b want 1111", {sv3, so3, sv0, so0});
        end
        run(1, 10, fd3, fd0, nd3, nd0, fp, vm);
        n_checks++;
        if (fd3 !== 6 || fd0 !== 6 || nd3 !== 1 || nd0 !== 1) begin
            n_fail++; $display("FAIL b2b_second_done: got %0d %0d count %0d %0d want 6 6 1 1", fd3, fd0, nd3, nd0);
        end
    endtask

    task automatic test_max_repeat;
        int fd3, fd0, nd3, nd0, fp;
        logic [255:0] vm;
        go(5'b11100, 4'd15, -1);
        run(1, 140, fd3, fd0, nd3, nd0, fp, vm);
        n_checks++;
        if (fd3 !== 126 || nd3 !== 1) begin
            n_fail++; $display("FAIL max_done3: got cycle %0d count %0d want 126 1", fd3, nd3);
        end
        n_checks++;
        if (fd0 !== 81 || nd0 !== 1) begin
            n_fail++; $display("FAIL max_done0: got cycle %0d count %0d want 81 1", fd0, nd0);
        end
        n_checks++;
        if ($countones(vm) !== 80) begin
            n_fail++; $display("FAIL max_valid_cycles: got %0d want 80", $countones(vm));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat_gap();
        test_start_ignored();
        test_abort();
        test_back_to_back();
        test_max_repeat();
        tick();
        n_checks++;
        if (q3.size() !== 0 || q0.size() !== 0) begin
            n_fail++; $display("FAIL final_queue: got %0d %0d pending want 0 0", q3.size(), q0.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
